alu_ctrl_seq: RTL

- Registered successor to the single-cycle ALU decoder.
- Decodes opcode bit 5, funct3, funct7 bits and the main-decoder alu_op into a full RV32I(+M) ALU control code.
- Holds the decoded operation in an output register with a valid/ready handshake.
- Sequences multi-cycle MUL/DIV operations by stalling its input until their latency has elapsed; sits at the ID/EX boundary feeding the ALU and MUL/DIV units.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_ctrl_decode.sv | 59 +++++
 rtl/alu_ctrl_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the registered ALU control decoder: operation codes, unit select
// and the alu_op classes produced by the main decoder.
package alu_pkg;

  localparam int unsigned CODE_W = 5;

  typedef enum logic [CODE_W-1:0] {
    AluAdd    = 5'b00000,
    AluSub    = 5'b00001,
    AluAnd    = 5'b00010,
    AluOr     = 5'b00011,
    AluXor    = 5'b00100,
    AluSll    = 5'b00101,
    AluSrl    = 5'b00110,
    AluSra    = 5'b00111,
    AluSlt    = 5'b01000,
    AluSltu   = 5'b01001,
    AluPassb  = 5'b01010,
    AluMul    = 5'b10000,
    AluMulh   = 5'b10001,
    AluMulhsu = 5'b10010,
    AluMulhu  = 5'b10011,
    AluDiv    = 5'b10100,
    AluDivu   = 5'b10101,
    AluRem    = 5'b10110,
    AluRemu   = 5'b10111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    UnitAlu = 2'd0,
    UnitMul = 2'd1,
    UnitDiv = 2'd2
  } unit_sel_e;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_PASSB = 2'b11;

  // M-extension codes are 1_0 followed by funct3.
  function automatic alu_ctrl_e m_code(input logic [2:0] funct3);
    return alu_ctrl_e'({2'b10, funct3});
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of alu_op/funct fields into an ALU control code, the target
// execution unit and an illegal-encoding flag.
module alu_ctrl_decode
  import alu_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       funct7_0,
  input  logic [1:0] alu_op,
  output alu_ctrl_e  code,
  output unit_sel_e  unit,
  output logic       illegal
);

  logic m_sel;
  logic sub_sel;

  assign m_sel   = op5 & funct7_0;
  assign sub_sel = op5 & funct7_5;

  always_comb begin
    code    = AluAdd;
    unit    = UnitAlu;
    illegal = 1'b0;
    case (alu_op)
      ALU_OP_ADD:   code = AluAdd;
      ALU_OP_SUB:   code = AluSub;
      ALU_OP_PASSB: code = AluPassb;
      default: begin
        if (m_sel) begin
          if (ENABLE_M) begin
            code = m_code(funct3);
            unit = funct3[2] ? UnitDiv : UnitMul;
          end else begin
            illegal = 1'b1;
          end
        end else if (sub_sel && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
          // funct7[5] is only meaningful for SUB and SRA.
          illegal = 1'b1;
        end else begin
          case (funct3)
            3'b000:  code = sub_sel ? AluSub : AluAdd;
            3'b001:  code = AluSll;
            3'b010:  code = AluSlt;
            3'b011:  code = AluSltu;
            3'b100:  code = AluXor;
            3'b101:  code = funct7_5 ? AluSra : AluSrl;
            3'b110:  code = AluOr;
            default: code = AluAnd;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control stage at ID/EX: decodes, holds the op behind a valid/ready
// handshake, and stalls the input for the latency of MUL/DIV operations.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int unsigned CTRL_W   = 5,
  parameter int unsigned ENABLE_M = 1,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned DIV_LAT  = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op5,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic              funct7_0,
  input  logic [1:0]        alu_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_control,
  output logic [1:0]        unit_sel,
  output logic              illegal
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

  typedef enum logic [1:0] {StEmpty, StWait, StFull} state_e;

  state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic      accept;

  alu_ctrl_e dec_code;
  unit_sel_e dec_unit;
  logic      dec_illegal;

  logic [CTRL_W-1:0] alu_control_q;
  logic [1:0]        unit_sel_q;
  logic              illegal_q;

  alu_ctrl_decode #(
    .ENABLE_M (ENABLE_M != 0)
  ) u_decode (
    .op5      (op5),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .funct7_0 (funct7_0),
    .alu_op   (alu_op),
    .code     (dec_code),
    .unit     (dec_unit),
    .illegal  (dec_illegal)
  );

  assign in_ready = ~flush & ((state_q == StEmpty) | ((state_q == StFull) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StEmpty, StFull: begin
        if (accept) begin
          case (dec_unit)
            UnitMul: begin
              state_d = StWait;
              cnt_d   = CntW'(MUL_LAT - 1);
            end
            UnitDiv: begin
              state_d = StWait;
              cnt_d   = CntW'(DIV_LAT - 1);
            end
            default: state_d = StFull;
          endcase
        end else if ((state_q == StFull) && out_ready) begin
          state_d = StEmpty;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StFull;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d = StEmpty;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StEmpty;
      cnt_q         <= '0;
      alu_control_q <= '0;
      unit_sel_q    <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        alu_control_q <= CTRL_W'(dec_code);
        unit_sel_q    <= dec_unit;
        illegal_q     <= dec_illegal;
      end
    end
  end

  assign out_valid   = (state_q == StFull);
  assign alu_control = alu_control_q;
  assign unit_sel    = unit_sel_q;
  assign illegal     = illegal_q;

endmodule
